// File: rtl/snake_dir_ctrl_if.sv
// Button/collision inputs and move/step/paused outputs of snake_dir_ctrl.
// The score signal exists only when SNAKE_SPEEDUP_EN is defined.
interface snake_dir_ctrl_if;
   logic [4:0] btn;
   logic       lose;
`ifdef SNAKE_SPEEDUP_EN
   logic [7:0] score;
`endif
   logic [2:0] move;
   logic       step;
   logic       paused;

   modport master (
`ifdef SNAKE_SPEEDUP_EN
      output score,
`endif
      output btn, lose,
      input  move, step, paused
   );

   modport slave (
`ifdef SNAKE_SPEEDUP_EN
      input  score,
`endif
      input  btn, lose,
      output move, step, paused
   );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake direction control: button debounce, 2-deep direction queue and step strobe.
// Optional SNAKE_SPEEDUP_EN shortens the step period as the score grows.
module snake_dir_ctrl #(
   parameter int unsigned STEP_DIV  = 6_250_000,
   parameter int unsigned DB_CYCLES = 250_000,
   parameter int unsigned SPEED_DEC = 50_000,
   parameter int unsigned MIN_DIV   = 2_500_000
) (
   input  logic             clk25,
   input  logic             reset,
   snake_dir_ctrl_if.slave  bus
);
   localparam int DBW = $clog2(DB_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DEAD} state_t;

   state_t           r_state;
   logic [4:0]       r_sync1, r_sync2, r_db, r_press;
   logic [DBW-1:0]   r_dbcnt [5];
   logic [1:0]       r_dir;
   logic [1:0]       r_q [2];
   logic [1:0]       r_qcnt;
   logic [31:0]      r_cnt;
   logic [2:0]       r_move;
   logic             r_step, r_paused;

   logic [31:0]      w_period;
   logic [3:0]       w_dpress;
   logic [1:0]       w_win, w_dir_p, w_q0_p, w_qcnt_p, w_ref;
   logic             w_wrap, w_pop, w_push;

   // r_press pulses for one cycle when a debounced bit rises
   always_ff @(posedge clk25) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_db    <= '0;
         r_press <= '0;
         for (int i = 0; i < 5; i++) r_dbcnt[i] <= '0;
      end else begin
         r_sync1 <= bus.btn;
         r_sync2 <= r_sync1;
         r_press <= '0;
         for (int i = 0; i < 5; i++) begin
            if (r_sync2[i] == r_db[i]) begin
               r_dbcnt[i] <= '0;
            end else if (r_dbcnt[i] == DBW'(DB_CYCLES - 1)) begin
               r_dbcnt[i] <= '0;
               r_db[i]    <= r_sync2[i];
               r_press[i] <= r_sync2[i];
            end else begin
               r_dbcnt[i] <= r_dbcnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef SNAKE_SPEEDUP_EN
   logic [31:0] w_dec;
   assign w_dec = 32'(bus.score) * SPEED_DEC;
   always_comb begin
      w_period = 32'(MIN_DIV);
      if (w_dec < STEP_DIV && (STEP_DIV - w_dec) > MIN_DIV) w_period = STEP_DIV - w_dec;
   end
`else
   assign w_period = 32'(STEP_DIV);
`endif

   // >= so that a period shrinking below the current count wraps at once
   assign w_wrap   = (r_cnt >= w_period - 32'd1);
   assign w_dpress = r_press[3:0];

   always_comb begin
      w_win = 2'd0;
      for (int i = 3; i >= 0; i--) if (w_dpress[i]) w_win = 2'(i);
   end

   // Pop happens before the push check, so pushes see the post-pop tail
   assign w_pop    = (r_state == S_RUN) && !bus.lose && !r_press[4] && w_wrap && (r_qcnt != 2'd0);
   assign w_dir_p  = w_pop ? r_q[0] : r_dir;
   assign w_q0_p   = w_pop ? r_q[1] : r_q[0];
   assign w_qcnt_p = r_qcnt - {1'b0, w_pop};
   assign w_ref    = (w_qcnt_p == 2'd0) ? w_dir_p : (w_qcnt_p == 2'd1) ? w_q0_p : r_q[1];
   assign w_push   = (|w_dpress) && !bus.lose && (r_state == S_RUN || r_state == S_PAUSE) &&
                     (w_win != w_ref) && (w_win != (w_ref ^ 2'b10)) && (w_qcnt_p != 2'd2);

   always_ff @(posedge clk25) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_dir    <= 2'b00;
         r_q[0]   <= 2'b00;
         r_q[1]   <= 2'b00;
         r_qcnt   <= 2'd0;
         r_cnt    <= 32'd0;
         r_move   <= 3'b100;
         r_step   <= 1'b0;
         r_paused <= 1'b1;
      end else begin
         r_step <= 1'b0;
         r_dir  <= w_dir_p;
         r_q[0] <= w_q0_p;
         r_qcnt <= w_qcnt_p + {1'b0, w_push};
         if (w_push) r_q[w_qcnt_p[0]] <= w_win;
         if (bus.lose) begin
            r_state  <= S_DEAD;
            r_move   <= 3'b100;
            r_paused <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: if (|w_dpress) begin
                  r_dir    <= w_win;
                  r_cnt    <= 32'd0;
                  r_state  <= S_RUN;
                  r_move   <= {1'b0, w_win};
                  r_paused <= 1'b0;
               end
               S_RUN: if (r_press[4]) begin
                  r_state  <= S_PAUSE;
                  r_move   <= 3'b100;
                  r_paused <= 1'b1;
               end else begin
                  if (w_wrap) begin
                     r_cnt  <= 32'd0;
                     r_step <= 1'b1;
                  end else begin
                     r_cnt  <= r_cnt + 32'd1;
                  end
                  r_move <= {1'b0, w_dir_p};
               end
               S_PAUSE: if (r_press[4]) begin
                  r_state  <= S_RUN;
                  r_move   <= {1'b0, r_dir};
                  r_paused <= 1'b0;
               end
               S_DEAD: ;
               default: ;
            endcase
         end
      end
   end

   assign bus.move   = r_move;
   assign bus.step   = r_step;
   assign bus.paused = r_paused;
endmodule
